// File: rtl/grid_pixel_pipe.sv
// Two-stage pixel merge: mouse overlay, cell-grid border, word glyphs and bitmap,
// plus a frame-counted blinking cursor cell that inverts glyph/bitmap pixels.
module grid_pixel_pipe #(
    parameter int          CELL_LOG2    = 5,
    parameter int          CW           = 12,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [CW-1:0] FG         = 12'hfff,
    parameter logic [CW-1:0] BG         = 12'h000,
    parameter logic [CW-1:0] GRID_ON    = 12'hccc,
    parameter logic [CW-1:0] GRID_OFF   = 12'h333
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [9:0]             i_h_cnt,
    input  logic [9:0]             i_v_cnt,
    input  logic                   i_grid_en,
    input  logic                   i_mouse_en,
    input  logic [CW-1:0]          i_mouse_pixel,
    input  logic                   i_mem_pixel,
    input  logic                   i_word_en,
    input  logic                   i_word_pixel,
    input  logic                   i_cursor_en,
    input  logic [9-CELL_LOG2:0]   i_cursor_col,
    input  logic [9-CELL_LOG2:0]   i_cursor_row,
    output logic [CW-1:0]          o_pixel,
    output logic                   o_pixel_valid,
    output logic                   o_blink_phase
);
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic          border;
        logic          cur_on;
        logic          mouse_en;
        logic [CW-1:0] mouse_pixel;
        logic          grid_en;
        logic          mem;
        logic          word_en;
        logic          word_pixel;
    } s1_t;

    logic [1:0]     r_vld_pipe;
    s1_t            r_s1;
    s1_t            w_s1;
    logic           r_tick_cond_d;
    logic [FCW-1:0] r_frame_cnt;
    logic [CW-1:0]  r_pixel;
    logic           w_tick_cond;
    logic           w_tick;
    logic           w_border;
    logic           w_hit;
    logic [CW-1:0]  w_base;
    logic           w_inv;

    wire [CELL_LOG2-1:0] w_h_lo = i_h_cnt[CELL_LOG2-1:0];
    wire [CELL_LOG2-1:0] w_v_lo = i_v_cnt[CELL_LOG2-1:0];

    assign w_border = (w_h_lo == '0) || (&w_h_lo) || (w_v_lo == '0) || (&w_v_lo);
    assign w_hit    = i_cursor_en && !w_border
                   && (i_h_cnt[9:CELL_LOG2] == i_cursor_col)
                   && (i_v_cnt[9:CELL_LOG2] == i_cursor_row);

    // Edge detect so a held (0,0) position ticks once even with a slow pixel clock.
    assign w_tick_cond = i_valid && (i_h_cnt == '0) && (i_v_cnt == '0);
    assign w_tick      = w_tick_cond && !r_tick_cond_d;

    always_comb begin
        w_s1.border      = w_border;
        w_s1.cur_on      = w_hit && o_blink_phase;
        w_s1.mouse_en    = i_mouse_en;
        w_s1.mouse_pixel = i_mouse_pixel;
        w_s1.grid_en     = i_grid_en;
        w_s1.mem         = i_mem_pixel;
        w_s1.word_en     = i_word_en;
        w_s1.word_pixel  = i_word_pixel;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tick_cond_d <= 1'b0;
            r_frame_cnt   <= '0;
            o_blink_phase <= 1'b0;
        end else begin
            r_tick_cond_d <= w_tick_cond;
            if (w_tick) begin
                if (r_frame_cnt == FC_LAST) begin
                    r_frame_cnt   <= '0;
                    o_blink_phase <= ~o_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // Cursor inversion only applies to glyph/bitmap colours, never mouse or border.
    always_comb begin
        w_base = BG;
        w_inv  = 1'b0;
        if (!r_vld_pipe[0])
            w_base = '0;
        else if (r_s1.mouse_en)
            w_base = r_s1.mouse_pixel;
        else if (r_s1.border && r_s1.grid_en)
            w_base = r_s1.mem ? GRID_ON : GRID_OFF;
        else begin
            if (r_s1.word_en)
                w_base = r_s1.word_pixel ? FG : BG;
            else
                w_base = r_s1.mem ? FG : BG;
            w_inv = r_s1.cur_on;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
            r_s1       <= '0;
            r_pixel    <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], i_valid};
            r_s1       <= w_s1;
            r_pixel    <= w_inv ? ~w_base : w_base;
        end
    end

    assign o_pixel       = r_pixel;
    assign o_pixel_valid = r_vld_pipe[1];
endmodule

// File: doc/grid_pixel_pipe.md
# grid_pixel_pipe

Parametrised, pipelined successor to the combinational grid pixel generator in the display path. It sits between the VGA timing counters and the VGA colour outputs, and merges four sources into one registered RGB pixel: the mouse overlay, a cell-grid border, word glyphs and the memory bitmap. On top of that merge it adds a frame-counted blinking cursor cell and a valid-aligned output. The grid geometry, colour width and palette are all parameters.

## Interface
Parameters:
- CELL_LOG2, 5, log2 of the cell edge in pixels; cells are square and 2^CELL_LOG2 pixels on a side; legal range 2..6
- CW, 12, colour width in bits
- BLINK_FRAMES, 30, number of frames per cursor blink half-period; must be ≥1
- FG, 12'hfff, foreground colour
- BG, 12'h000, background colour
- GRID_ON, 12'hccc, border colour when mem_pixel=1
- GRID_OFF, 12'h333, border colour when mem_pixel=0

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- valid  in  1  the timing generator is in the active display area
- h_cnt  in  10  horizontal pixel position
- v_cnt  in  10  vertical pixel position
- grid_en  in  1  enables drawing of cell borders
- mouse_en  in  1  the mouse overlay covers this pixel
- mouse_pixel  in  CW  mouse overlay colour
- mem_pixel  in  1  bitmap bit for this pixel
- word_en  in  1  word display mode
- word_pixel  in  1  glyph bit for this pixel
- cursor_en  in  1  enables the cursor
- cursor_col  in  10-CELL_LOG2  column index of the cursor cell
- cursor_row  in  10-CELL_LOG2  row index of the cursor cell
- pixel  out  CW  registered output colour
- pixel_valid  out  1  valid, delayed to align with pixel
- blink_phase  out  1  current cursor phase; 1 means the cursor is shown

## Operation
- Border pixel: the low CELL_LOG2 bits of h_cnt or of v_cnt are all zeros or all ones.
- Cell index: column = h_cnt >> CELL_LOG2, row = v_cnt >> CELL_LOG2.
- Cursor hit: cursor_en is set, the cell index equals (cursor_col, cursor_row), and the pixel is not a border pixel.
- Base colour, in strict priority order:
  1. !valid → 0
  2. mouse_en → mouse_pixel
  3. border && grid_en → mem_pixel ? GRID_ON : GRID_OFF
  4. word_en → word_pixel ? FG : BG (the glyph bit is expanded to a full palette colour, never zero-extended)
  5. otherwise → mem_pixel ? FG : BG
- Cursor: when the cursor hits, blink_phase=1 and the base colour came from rule 4 or rule 5, the output is the bitwise inversion of the base colour. The cursor has no effect on rules 1-3.
- Frame tick: one-cycle pulse on the rising edge of (valid && h_cnt==0 && v_cnt==0).
  - Because of the edge detect, the tick fires exactly once per frame even when clk runs faster than the pixel rate and the counters hold for several cycles.
- Blink counter: frame_cnt counts from 0 to BLINK_FRAMES-1.
  - On a tick at the terminal count, frame_cnt returns to 0 and blink_phase toggles.
  - On any other tick, frame_cnt increments.
  - With BLINK_FRAMES=1, blink_phase toggles on every frame.
- When cursor_en is 0, the counter keeps running; only the visible effect is suppressed.

## Timing
- Two-stage pipeline:
  - Stage 1 registers valid, the border, hit and mouse flags, and all pixel inputs.
  - Stage 2 registers pixel and pixel_valid.
  - Inputs sampled at edge N appear on pixel at edge N+2.
- Throughput is one pixel per clk, with no stalls.
- blink_phase changes in the cycle after the frame tick. It is sampled in stage 1, so the new phase first affects pixels sampled at or after that edge.
- The frame-tick edge detector uses a one-cycle-delayed copy of its condition; that copy resets to 0.
  - Consequence: if reset deasserts while the condition is already true, a tick fires on the first clock after reset.
- Reset values: pixel=0, pixel_valid=0, blink_phase=0, frame_cnt=0, all stage-1 registers 0.
- Reset asserted mid-frame clears everything immediately, without waiting for a clock edge.
  - The output stays 0 until two clocks after the first valid input following reset.
- cursor_col and cursor_row may change at any time; each pixel uses the values sampled together with it in stage 1.

## Test plan
- Reset and first pixel: assert rst, then release with valid=1, h=5, v=5, mem=1, grid_en=1. Required: pixel=0 and pixel_valid=0 during reset; pixel=FFF and pixel_valid=1 two cycles after release.
- Border and priority:
  - h=32, v=40, mem=0, grid_en=1 → 333
  - same inputs with mouse_en=1, mouse_pixel=0F0 → 0F0
  - same inputs with grid_en=0, word_en=1, word_pixel=1 → FFF
- Cursor blink with BLINK_FRAMES=2, cursor at (1,1), h=40, v=40, mem=0. Drive frame ticks and check blink_phase: 0→1 on the 2nd tick, back to 0 on the 4th. Required pixel: FFF while phase=1, 000 while phase=0; at h=32 (border) the pixel stays 333 in both phases.
- Slow pixel clock: hold h=0, v=0, valid=1 for 4 cycles. Required: exactly one frame tick, so frame_cnt advances by 1.
- Invalid region: valid=0 with mouse_en=1 → pixel=0, pixel_valid=0 after 2 cycles.
- Mid-stream reset: pulse rst during a cursor-on frame. Required: blink_phase=0, frame_cnt=0 and pixel=0 asynchronously, without waiting for a clock edge.
